// File: rtl/regfile_pkg.sv
// regfile_pkg: shared FSM encoding, default sizes and flattened-bus field extraction
package regfile_pkg;
  typedef enum logic {ST_IDLE = 1'b0, ST_CLEAR = 1'b1} state_t;
  localparam int XLEN_DEF = 32;
  localparam int NREGS_DEF = 32;
  localparam int FIELD_MAX = 128;
  localparam int BUS_MAX = 4096;
  function automatic logic [FIELD_MAX-1:0] bus_field(input logic [BUS_MAX-1:0] bus, input int k, input int w);
    return FIELD_MAX'(bus >> (k * w)) & ~({FIELD_MAX{1'b1}} << w);
  endfunction
endpackage

// File: rtl/regfile_wr_arbiter.sv
// regfile_wr_arbiter: per-address write winner (highest port), drop detection and bypass data
module regfile_wr_arbiter import regfile_pkg::*; #(
  parameter int XLEN = XLEN_DEF,
  parameter int NREGS = NREGS_DEF,
  parameter int NR_WR = 1,
  parameter int ZERO_REG = 1,
  parameter int AW = $clog2(NREGS)
) (
  input  logic                  i_block,
  input  logic [NR_WR-1:0]      i_wr_en,
  input  logic [NR_WR*AW-1:0]   i_wr_addr,
  input  logic [NR_WR*XLEN-1:0] i_wr_data,
  output logic [NREGS-1:0]      o_we,
  output logic [XLEN-1:0]       o_wd [NREGS],
  output logic                  o_drop
);
  logic [AW-1:0] w_addr;
  logic          w_ok;
  always_comb begin
    o_we = '0;
    o_wd = '{default: '0};
    o_drop = 1'b0;
    w_addr = '0;
    w_ok = 1'b0;
    for (int p = 0; p < NR_WR; p++) begin
      w_addr = AW'(bus_field(BUS_MAX'(i_wr_addr), p, AW));
      w_ok = i_wr_en[p] && !i_block && int'(w_addr) < NREGS && !(ZERO_REG != 0 && w_addr == '0);
      o_drop = o_drop || (i_wr_en[p] && !w_ok);
      if (w_ok) begin
        o_we[w_addr] = 1'b1;
        o_wd[w_addr] = XLEN'(bus_field(BUS_MAX'(i_wr_data), p, XLEN));
      end
    end
  end
endmodule

// File: rtl/regfile_mp.sv
// regfile_mp: multi-port register file with clear sweep; define REGFILE_BYPASS_EN for write-to-read forwarding
module regfile_mp import regfile_pkg::*; #(
  parameter int XLEN = XLEN_DEF,
  parameter int NREGS = NREGS_DEF,
  parameter int NR_RD = 2,
  parameter int NR_WR = 1,
  parameter int ZERO_REG = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clear_i,
  input  logic [NR_RD*((NREGS > 1) ? $clog2(NREGS) : 1)-1:0] rd_addr_i,
  output logic [NR_RD*XLEN-1:0] rd_data_o,
  input  logic [NR_WR-1:0]      wr_en_i,
  input  logic [NR_WR*((NREGS > 1) ? $clog2(NREGS) : 1)-1:0] wr_addr_i,
  input  logic [NR_WR*XLEN-1:0] wr_data_i,
  output logic                  busy_o,
  output logic                  wr_drop_o
);
  localparam int AW = (NREGS > 1) ? $clog2(NREGS) : 1;
  state_t          r_state, w_state_nxt;
  logic [AW-1:0]   r_idx, w_idx_nxt;
  logic            r_drop;
  logic [XLEN-1:0] r_mem [NREGS];
  logic [NREGS-1:0] w_we;
  logic [XLEN-1:0] w_wd [NREGS];
  logic            w_drop;
  logic [AW-1:0]   w_ra;
  logic [XLEN-1:0] w_rd;
  assign busy_o = reset || (r_state == ST_CLEAR);
  assign wr_drop_o = r_drop;
  // a clear request in IDLE refuses that cycle's writes as well
  regfile_wr_arbiter #(
    .XLEN(XLEN), .NREGS(NREGS), .NR_WR(NR_WR), .ZERO_REG(ZERO_REG), .AW(AW)
  ) u_arb (
    .i_block(busy_o || clear_i),
    .i_wr_en(wr_en_i),
    .i_wr_addr(wr_addr_i),
    .i_wr_data(wr_data_i),
    .o_we(w_we),
    .o_wd(w_wd),
    .o_drop(w_drop)
  );
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_CLEAR;
      r_idx <= '0;
      r_drop <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_idx <= w_idx_nxt;
      r_drop <= w_drop;
    end
  end
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt = r_idx;
    if (r_state == ST_CLEAR) begin
      w_idx_nxt = (int'(r_idx) == NREGS - 1) ? '0 : r_idx + 1'b1;
      w_state_nxt = (int'(r_idx) == NREGS - 1) ? ST_IDLE : ST_CLEAR;
    end else if (clear_i) begin
      w_state_nxt = ST_CLEAR;
      w_idx_nxt = '0;
    end
  end
  always_ff @(posedge clk) begin
    if (r_state == ST_CLEAR)
      r_mem[r_idx] <= '0;
    else
      for (int r = 0; r < NREGS; r++)
        if (w_we[r]) r_mem[r] <= w_wd[r];
  end
  always_comb begin
    rd_data_o = '0;
    w_ra = '0;
    w_rd = '0;
    for (int k = 0; k < NR_RD; k++) begin
      w_ra = AW'(bus_field(BUS_MAX'(rd_addr_i), k, AW));
      w_rd = r_mem[w_ra];
`ifdef REGFILE_BYPASS_EN
      if (w_we[w_ra]) w_rd = w_wd[w_ra];
`endif
      rd_data_o[k*XLEN +: XLEN] = (busy_o || int'(w_ra) >= NREGS || (ZERO_REG != 0 && w_ra == '0)) ? '0 : w_rd;
    end
  end
endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: directed checks of a 32x2R2W file and a 24-entry 1R1W file
module tb_regfile_mp;
`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        clear = 1'b0;
  logic [9:0]  rd_addr = '0;
  logic [63:0] rd_data;
  logic [1:0]  wr_en = '0;
  logic [9:0]  wr_addr = '0;
  logic [63:0] wr_data = '0;
  logic        busy, drop;
  logic        reset24 = 1'b1;
  logic [4:0]  rd_addr24 = '0;
  logic [31:0] rd_data24;
  logic        wr_en24 = 1'b0;
  logic [4:0]  wr_addr24 = '0;
  logic [31:0] wr_data24 = '0;
  logic        busy24, drop24;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  regfile_mp #(.XLEN(32), .NREGS(32), .NR_RD(2), .NR_WR(2), .ZERO_REG(1)) u_dut (
    .clk(clk), .reset(reset), .clear_i(clear),
    .rd_addr_i(rd_addr), .rd_data_o(rd_data),
    .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
    .busy_o(busy), .wr_drop_o(drop)
  );
  regfile_mp #(.XLEN(32), .NREGS(24), .NR_RD(1), .NR_WR(1), .ZERO_REG(1)) u_dut24 (
    .clk(clk), .reset(reset24), .clear_i(1'b0),
    .rd_addr_i(rd_addr24), .rd_data_o(rd_data24),
    .wr_en_i(wr_en24), .wr_addr_i(wr_addr24), .wr_data_i(wr_data24),
    .busy_o(busy24), .wr_drop_o(drop24)
  );
  task automatic count_busy(input bit sel, output int n);
    n = 0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (!(sel ? busy24 : busy)) break;
      n++;
    end
  endtask
  task automatic test_reset();
    int n;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL reset_busy got %0b exp 1", busy); end
    @(posedge clk); #1 reset = 1'b0;
    count_busy(1'b0, n);
    checks++; if (n != 32) begin errors++; $display("FAIL reset_sweep_len got %0d exp 32", n); end
    checks++; if (drop !== 1'b0) begin errors++; $display("FAIL reset_drop got %0b exp 0", drop); end
    for (int i = 0; i < 16; i++) begin
      rd_addr = {5'(2*i+1), 5'(2*i)};
      #1;
      checks++; if (rd_data !== 64'h0) begin errors++; $display("FAIL reset_read x%0d got %h exp 0", 2*i, rd_data); end
    end
  endtask
  task automatic test_write_read();
    wr_en = 2'b01; wr_addr = {5'd0, 5'd5}; wr_data = {32'h0, 32'hDEADBEEF};
    @(posedge clk); #1 wr_en = '0; rd_addr = {5'd0, 5'd5};
    @(negedge clk);
    checks++; if (rd_data[31:0] !== 32'hDEADBEEF) begin errors++; $display("FAIL wr_x5 got %h exp deadbeef", rd_data[31:0]); end
    checks++; if (drop !== 1'b0) begin errors++; $display("FAIL wr_x5_drop got %0b exp 0", drop); end
    wr_en = 2'b01; wr_addr = {5'd0, 5'd0}; wr_data = {32'h0, 32'h1};
    @(posedge clk); #1 wr_en = '0; rd_addr = {5'd0, 5'd0};
    @(negedge clk);
    checks++; if (rd_data[31:0] !== 32'h0) begin errors++; $display("FAIL wr_x0 got %h exp 0", rd_data[31:0]); end
    checks++; if (drop !== 1'b1) begin errors++; $display("FAIL wr_x0_drop got %0b exp 1", drop); end
    @(negedge clk);
    checks++; if (drop !== 1'b0) begin errors++; $display("FAIL drop_pulse got %0b exp 0", drop); end
    wr_en = 2'b10; wr_addr = {5'd6, 5'd0}; wr_data = {32'h12345678, 32'h0};
    @(posedge clk); #1 wr_en = '0; rd_addr = {5'd6, 5'd5};
    @(negedge clk);
    checks++; if (rd_data !== {32'h12345678, 32'hDEADBEEF}) begin errors++; $display("FAIL wr_port1 got %h exp 12345678deadbeef", rd_data); end
  endtask
  task automatic test_conflict();
    wr_en = 2'b11; wr_addr = {5'd7, 5'd7}; wr_data = {32'h22, 32'h11};
    @(posedge clk); #1 wr_en = '0; rd_addr = {5'd0, 5'd7};
    @(negedge clk);
    checks++; if (rd_data[31:0] !== 32'h22) begin errors++; $display("FAIL conflict_x7 got %h exp 22", rd_data[31:0]); end
    checks++; if (drop !== 1'b0) begin errors++; $display("FAIL conflict_drop got %0b exp 0", drop); end
    wr_en = 2'b11; wr_addr = {5'd11, 5'd10}; wr_data = {32'hB, 32'hA};
    @(posedge clk); #1 wr_en = '0; rd_addr = {5'd11, 5'd10};
    @(negedge clk);
    checks++; if (rd_data !== {32'hB, 32'hA}) begin errors++; $display("FAIL dual_write got %h exp 0000000b0000000a", rd_data); end
  endtask
  task automatic test_clear();
    int n;
    for (int i = 1; i < 32; i++) begin
      wr_en = 2'b01; wr_addr = {5'd0, 5'(i)}; wr_data = {32'h0, 32'(i)};
      @(posedge clk); #1;
    end
    wr_en = '0; rd_addr = {5'd1, 5'd31};
    #1;
    checks++; if (rd_data !== {32'd1, 32'd31}) begin errors++; $display("FAIL fill got %h exp 000000010000001f", rd_data); end
    clear = 1'b1; wr_en = 2'b01; wr_addr = {5'd0, 5'd3}; wr_data = {32'h0, 32'h99};
    @(posedge clk); #1 clear = 1'b0; wr_en = '0;
    checks++; if (drop !== 1'b1) begin errors++; $display("FAIL clear_wr_drop got %0b exp 1", drop); end
    n = 0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (!busy) break;
      n++;
      clear = (n == 5);
      if (n == 8) begin wr_en = 2'b01; wr_addr = {5'd0, 5'd4}; wr_data = {32'h0, 32'h55}; end
      if (n == 9) begin
        wr_en = '0;
        checks++; if (drop !== 1'b1) begin errors++; $display("FAIL busy_wr_drop got %0b exp 1", drop); end
      end
    end
    clear = 1'b0;
    checks++; if (n != 32) begin errors++; $display("FAIL clear_sweep_len got %0d exp 32", n); end
    for (int i = 0; i < 16; i++) begin
      rd_addr = {5'(2*i+1), 5'(2*i)};
      #1;
      checks++; if (rd_data !== 64'h0) begin errors++; $display("FAIL cleared x%0d got %h exp 0", 2*i, rd_data); end
    end
  endtask
  task automatic test_bypass();
    wr_en = 2'b01; wr_addr = {5'd0, 5'd9}; wr_data = {32'h0, 32'h1111};
    @(posedge clk); #1;
    wr_data = {32'h0, 32'hA5A5A5A5}; rd_addr = {5'd12, 5'd9};
    #1;
    checks++; if (rd_data[31:0] !== (BYP ? 32'hA5A5A5A5 : 32'h1111)) begin errors++; $display("FAIL bypass_same got %h exp %h", rd_data[31:0], BYP ? 32'hA5A5A5A5 : 32'h1111); end
    @(posedge clk); #1 wr_en = '0;
    #1;
    checks++; if (rd_data[31:0] !== 32'hA5A5A5A5) begin errors++; $display("FAIL bypass_next got %h exp a5a5a5a5", rd_data[31:0]); end
    wr_en = 2'b01; wr_addr = {5'd0, 5'd0}; wr_data = {32'h0, 32'hFF}; rd_addr = {5'd12, 5'd0};
    #1;
    checks++; if (rd_data[31:0] !== 32'h0) begin errors++; $display("FAIL bypass_x0 got %h exp 0", rd_data[31:0]); end
    @(posedge clk); #1;
    wr_en = 2'b11; wr_addr = {5'd12, 5'd12}; wr_data = {32'h2, 32'h1};
    #1;
    checks++; if (rd_data[63:32] !== (BYP ? 32'h2 : 32'h0)) begin errors++; $display("FAIL bypass_multi got %h exp %h", rd_data[63:32], BYP ? 32'h2 : 32'h0); end
    @(posedge clk); #1 wr_en = '0;
    #1;
    checks++; if (rd_data[63:32] !== 32'h2) begin errors++; $display("FAIL bypass_multi_next got %h exp 2", rd_data[63:32]); end
  endtask
  task automatic test_boundary24();
    int n;
    @(posedge clk); #1 reset24 = 1'b0;
    n = 0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (!busy24) break;
      n++;
      if (n == 11) begin reset24 = 1'b1; break; end
    end
    checks++; if (n != 11) begin errors++; $display("FAIL sweep24_pre got %0d exp 11", n); end
    @(negedge clk);
    checks++; if (busy24 !== 1'b1) begin errors++; $display("FAIL reset24_busy got %0b exp 1", busy24); end
    @(posedge clk); #1 reset24 = 1'b0;
    count_busy(1'b1, n);
    checks++; if (n != 24) begin errors++; $display("FAIL sweep24_len got %0d exp 24", n); end
    wr_en24 = 1'b1; wr_addr24 = 5'd30; wr_data24 = 32'h77; rd_addr24 = 5'd30;
    @(posedge clk); #1 wr_en24 = 1'b0;
    @(negedge clk);
    checks++; if (drop24 !== 1'b1) begin errors++; $display("FAIL oor_drop got %0b exp 1", drop24); end
    checks++; if (rd_data24 !== 32'h0) begin errors++; $display("FAIL oor_read got %h exp 0", rd_data24); end
    wr_en24 = 1'b1; wr_addr24 = 5'd23; wr_data24 = 32'hABC; rd_addr24 = 5'd23;
    @(posedge clk); #1 wr_en24 = 1'b0;
    @(negedge clk);
    checks++; if (drop24 !== 1'b0) begin errors++; $display("FAIL last_drop got %0b exp 0", drop24); end
    checks++; if (rd_data24 !== 32'hABC) begin errors++; $display("FAIL last_read got %h exp abc", rd_data24); end
    wr_en24 = 1'b1; wr_addr24 = 5'd24; wr_data24 = 32'h5; rd_addr24 = 5'd24;
    @(posedge clk); #1 wr_en24 = 1'b0;
    @(negedge clk);
    checks++; if (drop24 !== 1'b1) begin errors++; $display("FAIL x24_drop got %0b exp 1", drop24); end
    checks++; if (rd_data24 !== 32'h0) begin errors++; $display("FAIL x24_read got %h exp 0", rd_data24); end
  endtask
  initial begin
    test_reset();
    test_write_read();
    test_conflict();
    test_clear();
    test_bypass();
    test_boundary24();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
